// File: rtl/des_cbc_if.sv
// des_cbc_if: plaintext/ciphertext handshakes plus the encryptor data/key/result bus
interface des_cbc_if;
  logic        start;
  logic [63:0] key_in;
  logic [63:0] iv_in;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        out_last;
  logic        busy;
  logic [63:0] core_data;
  logic [63:0] core_key;
  logic [63:0] core_result;
  modport master (
    output start, key_in, iv_in, in_valid, in_data, in_last, out_ready, core_result,
    input  in_ready, out_valid, out_data, out_last, busy, core_data, core_key
  );
  modport slave (
    input  start, key_in, iv_in, in_valid, in_data, in_last, out_ready, core_result,
    output in_ready, out_valid, out_data, out_last, busy, core_data, core_key
  );
endinterface

// File: rtl/des_cbc_ctrl.sv
// des_cbc_ctrl: CBC chaining controller wrapped around a fixed-latency DES encryptor
module des_cbc_ctrl #(
  parameter int CORE_LATENCY = 16
) (
  input logic      clk,
  input logic      rst,
  des_cbc_if.slave bus
);
  localparam int CW = $clog2(CORE_LATENCY + 1);
  typedef enum logic [1:0] {IDLE, WAIT_BLK, RUN, OUT} state_t;
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [63:0]     chain_q, chain_d;
  logic [63:0]     core_data_q, core_data_d;
  logic [63:0]     core_key_q, core_key_d;
  logic [63:0]     out_data_q, out_data_d;
  logic            out_last_q, out_last_d;
  logic            last_q, last_d;
  assign bus.in_ready  = state_q == WAIT_BLK;
  assign bus.out_valid = state_q == OUT;
  assign bus.busy      = state_q != IDLE;
  assign bus.core_data = core_data_q;
  assign bus.core_key  = core_key_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  // Next-state logic: the counter only restarts on an accept, so stale pipeline data is never captured
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    chain_d     = chain_q;
    core_data_d = core_data_q;
    core_key_d  = core_key_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    last_d      = last_q;
    case (state_q)
      IDLE: if (bus.start) begin
        core_key_d = bus.key_in;
        chain_d    = bus.iv_in;
        state_d    = WAIT_BLK;
      end
      WAIT_BLK: if (bus.in_valid) begin
        core_data_d = bus.in_data ^ chain_q;
        last_d      = bus.in_last;
        cnt_d       = '0;
        state_d     = RUN;
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(CORE_LATENCY)) begin
          out_data_d = bus.core_result;
          chain_d    = bus.core_result;
          out_last_d = last_q;
          state_d    = OUT;
        end
      end
      OUT: if (bus.out_ready) state_d = last_q ? IDLE : WAIT_BLK;
      default: state_d = IDLE;
    endcase
  end
  // State and datapath registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      chain_q     <= '0;
      core_data_q <= '0;
      core_key_q  <= '0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      chain_q     <= chain_d;
      core_data_q <= core_data_d;
      core_key_q  <= core_key_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      last_q      <= last_d;
    end
  end
endmodule
